// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle datapath controller:
// FSM states, opcode classes, mux-select encodings and default opcodes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_TRAP    = 4'd11
  } state_e;

  // One-hot instruction class; exactly one member is set.
  typedef struct packed {
    logic r;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic bad;
  } op_class_t;

  localparam op_class_t CLASS_R = '{r: 1'b1, default: 1'b0};

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_TRAP   = 2'b11;

  localparam logic [5:0] DEF_OP_R   = 6'b000000;
  localparam logic [5:0] DEF_OP_LW  = 6'b100011;
  localparam logic [5:0] DEF_OP_SW  = 6'b101011;
  localparam logic [5:0] DEF_OP_BEQ = 6'b000100;
  localparam logic [5:0] DEF_OP_BNE = 6'b111011;
  localparam logic [5:0] DEF_OP_J   = 6'b100001;

endpackage

// File: rtl/multicycle_control_opcode_classify.sv
// Maps an opcode to a one-hot instruction class. Unknown opcodes become
// `bad` when trapping is enabled, otherwise they execute as R-format.
module opcode_classify
  import multicycle_control_pkg::*;
#(
  parameter int               OPCODE_W = 6,
  parameter logic [OPCODE_W-1:0] OP_R   = DEF_OP_R,
  parameter logic [OPCODE_W-1:0] OP_LW  = DEF_OP_LW,
  parameter logic [OPCODE_W-1:0] OP_SW  = DEF_OP_SW,
  parameter logic [OPCODE_W-1:0] OP_BEQ = DEF_OP_BEQ,
  parameter logic [OPCODE_W-1:0] OP_BNE = DEF_OP_BNE,
  parameter logic [OPCODE_W-1:0] OP_J   = DEF_OP_J,
  parameter bit                TRAP_EN  = 1'b1
) (
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           cls
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cls = '0;
    if      (opcode == OP_R)   cls.r   = 1'b1;
    else if (opcode == OP_LW)  cls.lw  = 1'b1;
    else if (opcode == OP_SW)  cls.sw  = 1'b1;
    else if (opcode == OP_BEQ) cls.beq = 1'b1;
    else if (opcode == OP_BNE) cls.bne = 1'b1;
    else if (opcode == OP_J)   cls.j   = 1'b1;
    else if (TRAP_EN)          cls.bad = 1'b1;
    else                       cls.r   = 1'b1;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: state, latched opcode class and sticky illegal
// flag are registered; all control outputs decode from state plus mem_ready/zero.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int               OPCODE_W = 6,
  parameter logic [OPCODE_W-1:0] OP_R   = DEF_OP_R,
  parameter logic [OPCODE_W-1:0] OP_LW  = DEF_OP_LW,
  parameter logic [OPCODE_W-1:0] OP_SW  = DEF_OP_SW,
  parameter logic [OPCODE_W-1:0] OP_BEQ = DEF_OP_BEQ,
  parameter logic [OPCODE_W-1:0] OP_BNE = DEF_OP_BNE,
  parameter logic [OPCODE_W-1:0] OP_J   = DEF_OP_J,
  parameter bit                TRAP_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                zero,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                iord,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                pc_en,
  output logic                illegal,
  output logic                instr_done,
  output logic [3:0]          state_o
);

  state_e    state_d, state_q;
  op_class_t cls_now, cls_d, cls_q;
  logic      illegal_d, illegal_q;

  opcode_classify #(
    .OPCODE_W(OPCODE_W), .OP_R(OP_R), .OP_LW(OP_LW), .OP_SW(OP_SW),
    .OP_BEQ(OP_BEQ), .OP_BNE(OP_BNE), .OP_J(OP_J), .TRAP_EN(TRAP_EN)
  ) u_classify (
    .opcode(opcode),
    .cls   (cls_now)
  );

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        // The class is captured here so later states never resample opcode.
        cls_d = cls_now;
        if      (cls_now.lw || cls_now.sw)   state_d = S_MEMADDR;
        else if (cls_now.beq || cls_now.bne) state_d = S_BRANCH;
        else if (cls_now.j)                  state_d = S_JUMP;
        else if (cls_now.bad) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
        else                                 state_d = S_EXEC;
      end
      S_MEMADDR: state_d = cls_q.lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC:    state_d = S_RWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_TRAP: state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cls_q     <= CLASS_R;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    pc_source  = PC_ALU;
    pc_en      = 1'b0;
    instr_done = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE:  alu_src_b = SRCB_IMM_SH;
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_source  = PC_ALUOUT;
        pc_en      = (cls_q.beq & zero) | (cls_q.bne & ~zero);
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_source  = PC_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      S_TRAP: begin
        pc_source = PC_TRAP;
        pc_en     = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table for the main
// instruction flows plus hand sequences for memory waits, traps and async reset.
module tb_multicycle_control;

  localparam logic [5:0] OPC_R   = 6'b000000;
  localparam logic [5:0] OPC_LW  = 6'b100011;
  localparam logic [5:0] OPC_SW  = 6'b101011;
  localparam logic [5:0] OPC_BEQ = 6'b000100;
  localparam logic [5:0] OPC_BNE = 6'b111011;
  localparam logic [5:0] OPC_J   = 6'b100001;
  localparam logic [5:0] OPC_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n, mem_ready, zero;
  logic [5:0] opcode;
  logic       mem_read, mem_write, ir_write, iord, reg_write, reg_dst;
  logic       mem_to_reg, alu_src_a, pc_en, illegal, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_o;

  logic       rst_n0, mem_ready0, zero0;
  logic [5:0] opcode0;
  logic       mem_read0, mem_write0, ir_write0, iord0, reg_write0, reg_dst0;
  logic       mem_to_reg0, alu_src_a0, pc_en0, illegal0, instr_done0;
  logic [1:0] alu_src_b0, alu_op0, pc_source0;
  logic [3:0] state_o0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .iord(iord),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .pc_en(pc_en), .illegal(illegal),
    .instr_done(instr_done), .state_o(state_o)
  );

  multicycle_control #(.TRAP_EN(1'b0)) dut_notrap (
    .clk(clk), .rst_n(rst_n0), .opcode(opcode0), .mem_ready(mem_ready0), .zero(zero0),
    .mem_read(mem_read0), .mem_write(mem_write0), .ir_write(ir_write0), .iord(iord0),
    .reg_write(reg_write0), .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0),
    .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_op(alu_op0),
    .pc_source(pc_source0), .pc_en(pc_en0), .illegal(illegal0),
    .instr_done(instr_done0), .state_o(state_o0)
  );

  // Output bundle: {mr,mw,irw,iord,rw,rd,m2r,asa,asb[2],aop[2],pcs[2],pce,ill,done,state[4]}
  function automatic logic [20:0] mk(input logic [3:0] st, input logic mr, mw, irw, io,
                                     rw, rd, m2r, asa, input logic [1:0] asb, aop, pcs,
                                     input logic pce, ill, dn);
    return {mr, mw, irw, io, rw, rd, m2r, asa, asb, aop, pcs, pce, ill, dn, st};
  endfunction

  function automatic logic [20:0] e_fetch(input logic rdy);
    return mk(4'd1, 1, 0, rdy, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, rdy, 0, 0);
  endfunction

  function automatic logic [20:0] e_decode();
    return mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0);
  endfunction

  function automatic logic [20:0] outs();
    return {mem_read, mem_write, ir_write, iord, reg_write, reg_dst, mem_to_reg,
            alu_src_a, alu_src_b, alu_op, pc_source, pc_en, illegal, instr_done, state_o};
  endfunction

  function automatic logic [20:0] outs0();
    return {mem_read0, mem_write0, ir_write0, iord0, reg_write0, reg_dst0, mem_to_reg0,
            alu_src_a0, alu_src_b0, alu_op0, pc_source0, pc_en0, illegal0, instr_done0,
            state_o0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [5:0] op, input logic mr, input logic z);
    @(negedge clk);
    opcode    = op;
    mem_ready = mr;
    zero      = z;
    #1;
  endtask

  task automatic step0(input logic [5:0] op, input logic mr);
    @(negedge clk);
    opcode0    = op;
    mem_ready0 = mr;
    zero0      = 1'b0;
    #1;
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       mr;
    logic       z;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic [5:0] op, input logic mr,
                     input logic z, input logic [20:0] exp);
    vec_t v;
    v.name = name; v.op = op; v.mr = mr; v.z = z; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] lw_states [8];
    logic       lw_ready  [8];

    rst_n = 1'b0; opcode = '0; mem_ready = 1'b0; zero = 1'b0;
    rst_n0 = 1'b0; opcode0 = '0; mem_ready0 = 1'b0; zero0 = 1'b0;

    // R-format, fetch wait, branches (incl. latched class), jump, SW with wait.
    add("r_fetch",      OPC_R,   1, 0, e_fetch(1));
    add("r_decode",     OPC_R,   1, 0, e_decode());
    add("r_exec",       OPC_R,   1, 0, mk(4'd7, 0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0,0,0));
    add("r_rwb",        OPC_R,   1, 0, mk(4'd8, 0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00, 0,0,1));
    add("fetch_wait",   OPC_BEQ, 0, 0, e_fetch(0));
    add("beq_fetch",    OPC_BEQ, 1, 0, e_fetch(1));
    add("beq_decode",   OPC_BEQ, 1, 0, e_decode());
    add("beq_taken",    OPC_BEQ, 1, 1, mk(4'd9, 0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 1,0,1));
    add("bne_fetch",    OPC_BNE, 1, 0, e_fetch(1));
    add("bne_decode",   OPC_BNE, 1, 0, e_decode());
    add("bne_zero1",    OPC_BEQ, 1, 1, mk(4'd9, 0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 0,0,1));
    add("bne2_fetch",   OPC_BNE, 1, 0, e_fetch(1));
    add("bne2_decode",  OPC_BNE, 1, 0, e_decode());
    add("bne_zero0",    OPC_BNE, 1, 0, mk(4'd9, 0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 1,0,1));
    add("j_fetch",      OPC_J,   1, 0, e_fetch(1));
    add("j_decode",     OPC_J,   1, 0, e_decode());
    add("j_jump",       OPC_J,   1, 0, mk(4'd10, 0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 1,0,1));
    add("sw_fetch",     OPC_SW,  1, 0, e_fetch(1));
    add("sw_decode",    OPC_SW,  1, 0, e_decode());
    add("sw_memaddr",   OPC_R,   1, 0, mk(4'd3, 0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0,0));
    add("sw_memwr_wait",OPC_R,   0, 0, mk(4'd6, 0,1,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0,0));
    add("sw_memwr_done",OPC_R,   1, 0, mk(4'd6, 0,1,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0,1));

    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", outs(), '0);

    @(negedge clk);
    rst_n = 1'b1; opcode = OPC_R; mem_ready = 1'b1;
    #1;
    check("idle_after_reset", outs(), '0);

    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].mr, vecs[i].z);
      check(vecs[i].name, outs(), vecs[i].exp);
    end

    // LW with two wait cycles in MEMRD: FETCH..FETCH spans 7 cycles.
    lw_states = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5, 4'd1};
    lw_ready  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      step(OPC_LW, lw_ready[i], 1'b0);
      check($sformatf("lw_state_%0d", i), state_o, lw_states[i]);
      if (i == 3)
        check("lw_memrd", outs(), mk(4'd4, 1,0,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0,0));
      if (i == 6)
        check("lw_memwb", outs(), mk(4'd5, 0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 0,0,1));
    end

    // Unknown opcode traps; illegal stays set over later instructions.
    step(OPC_BAD, 1'b1, 1'b0);
    check("trap_fetch", outs(), e_fetch(1));
    step(OPC_BAD, 1'b1, 1'b0);
    check("trap_decode", outs(), e_decode());
    step(OPC_R, 1'b1, 1'b0);
    check("trap_state", outs(), mk(4'd11, 0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b11, 1,1,0));
    for (int k = 0; k < 10; k++) begin
      step(OPC_J, 1'b1, 1'b0);
      step(OPC_J, 1'b1, 1'b0);
      step(OPC_J, 1'b1, 1'b0);
      check($sformatf("sticky_illegal_%0d", k), {illegal, instr_done, state_o}, {1'b1, 1'b1, 4'd10});
    end

    // Async reset while MEMWR waits on memory.
    step(OPC_SW, 1'b1, 1'b0);
    step(OPC_SW, 1'b1, 1'b0);
    step(OPC_SW, 1'b1, 1'b0);
    step(OPC_SW, 1'b0, 1'b0);
    check("memwr_before_reset", {mem_write, state_o}, {1'b1, 4'd6});
    #1;
    rst_n = 1'b0;
    #1;
    check("memwr_async_reset", outs(), '0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    #1;
    check("reset_release_idle", outs(), '0);
    step(OPC_R, 1'b1, 1'b0);
    check("reset_release_fetch", outs(), e_fetch(1));

    // TRAP_EN=0: unknown opcode runs the R-format path, illegal never sets.
    @(negedge clk);
    rst_n0 = 1'b1; opcode0 = OPC_BAD; mem_ready0 = 1'b1;
    #1;
    check("notrap_idle", outs0(), '0);
    step0(OPC_BAD, 1'b1);
    step0(OPC_BAD, 1'b1);
    check("notrap_decode", outs0(), e_decode());
    step0(OPC_BAD, 1'b1);
    check("notrap_exec", outs0(), mk(4'd7, 0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0,0,0));
    step0(OPC_BAD, 1'b1);
    check("notrap_rwb", outs0(), mk(4'd8, 0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00, 0,0,1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OPCODE_W, default 6: opcode field width.
REQ-002 Parameters OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, defaults 6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b111011, 6'b100001: opcode encodings.
REQ-003 Parameter TRAP_EN, default 1: 1 = unknown opcode traps; 0 = unknown opcode treated as R-format.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 opcode  input  OPCODE_W  instruction-register opcode, sampled in DECODE.
REQ-007 mem_ready  input  1  memory access complete this cycle.
REQ-008 zero  input  1  ALU zero flag.
REQ-009 mem_read, mem_write, ir_write, iord  output  1 each  memory/IR control.
REQ-010 reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  register-file/ALU control.
REQ-011 alu_src_b  output  2  00 reg B, 01 const 4, 10 sign-extended imm, 11 shifted imm.
REQ-012 alu_op  output  2  00 add, 01 sub, 10 funct-decoded.
REQ-013 pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 trap vector.
REQ-014 pc_en  output  1  PC load enable, branch condition already applied.
REQ-015 illegal  output  1  sticky illegal-opcode flag.
REQ-016 instr_done  output  1  one-cycle pulse per retired instruction.
REQ-017 state_o  output  4  current state encoding, debug.

Function
REQ-018 States: IDLE, FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, TRAP.
REQ-019 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-020 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_en=1 only in the cycle mem_ready=1; stay in FETCH while mem_ready=0.
REQ-021 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by opcode: LW/SW to MEMADDR, R to EXEC, BEQ/BNE to BRANCH, J to JUMP, other opcodes to TRAP (TRAP_EN=1) or EXEC (TRAP_EN=0).
REQ-022 MEMADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD for LW, MEMWR for SW; opcode is latched in DECODE, not resampled.
REQ-023 MEMRD: mem_read=1, iord=1; hold until mem_ready=1, then MEMWB.
REQ-024 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; next FETCH.
REQ-025 MEMWR: mem_write=1, iord=1; hold until mem_ready=1; in that cycle instr_done=1 and next FETCH.
REQ-026 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next RWB.
REQ-027 RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; next FETCH.
REQ-028 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01; pc_en = zero for BEQ, ~zero for BNE; instr_done=1; next FETCH.
REQ-029 JUMP: pc_source=10, pc_en=1, instr_done=1; next FETCH.
REQ-030 TRAP: pc_source=11, pc_en=1, illegal set; next FETCH; illegal stays 1 until reset.
REQ-031 Every output not listed for a state is 0 in that state.
REQ-032 State register is the only sequential state besides the latched opcode class and illegal; outputs decode combinationally from state plus mem_ready/zero.
REQ-033 Latency: R-format 4 cycles, LW 5, SW 4, BEQ/BNE 3, J 3, trap 3, each plus memory wait cycles.

Reset
REQ-034 rst_n low forces state IDLE, illegal 0 and latched opcode class R immediately, regardless of clk.
REQ-035 While rst_n is low all outputs are 0, including outputs of an access in flight; release mid-operation always restarts from IDLE, then FETCH.

Structure
REQ-036 A shared package holds the state enumeration, alu_src_b/alu_op/pc_source encodings and default opcode constants.
REQ-037 One sub-module, opcode_classify, maps opcode and parameters to a one-hot class {r, lw, sw, beq, bne, j, bad}.

Verification
REQ-038 Reset, then opcode=000000, mem_ready=1 -> states IDLE, FETCH, DECODE, EXEC, RWB; reg_write=1 and reg_dst=1 in RWB; instr_done pulses once.
REQ-039 LW (100011) with mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles; MEMWB has mem_to_reg=1; total 7 cycles FETCH to FETCH.
REQ-040 BEQ with zero=1 -> pc_en=1 with pc_source=01 in BRANCH; BNE (111011) with zero=1 -> pc_en=0.
REQ-041 Opcode 111111, TRAP_EN=1 -> TRAP with pc_source=11 and pc_en=1, illegal stays 1 over 10 further instructions; TRAP_EN=0 -> EXEC path, illegal=0.
REQ-042 rst_n dropped while in MEMWR with mem_ready=0 -> mem_write falls to 0 without a clk edge; after release, IDLE then FETCH.
